// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage load/store engine.
package dmem_pkg;

    // Access size as carried by the M stage; 2'b11 is handled as a word.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    // Load extension select, taken directly from funct3.
    localparam logic [2:0] EXT_LB  = 3'b000;
    localparam logic [2:0] EXT_LH  = 3'b001;
    localparam logic [2:0] EXT_LW  = 3'b010;
    localparam logic [2:0] EXT_LBU = 3'b100;
    localparam logic [2:0] EXT_LHU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        DONE
    } state_e;

    // An access needs two bus words when its bytes straddle a word boundary.
    function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || (size[1] && (off != 2'd0));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, store data positioning and
// load data extraction with sign/zero extension over a two-word window.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  ext,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  be8,
    output logic [63:0] wdata64,
    output logic [31:0] load_data
);

    logic [7:0]  mask;
    logic [63:0] window;
    logic [31:0] raw;

    // Build the two-word byte mask, shifted store data and extended load value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        mask      = 8'h0F;
        load_data = 32'h0;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            default: mask = 8'h0F;
        endcase
        be8     = mask << off;
        wdata64 = {32'h0, wdata} << {off, 3'b000};
        window  = {hi, lo} >> {off, 3'b000};
        raw     = window[31:0];
        case (ext)
            EXT_LB:  load_data = {{24{raw[7]}}, raw[7:0]};
            EXT_LH:  load_data = {{16{raw[15]}}, raw[15:0]};
            EXT_LBU: load_data = {24'h0, raw[7:0]};
            EXT_LHU: load_data = {16'h0, raw[15:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store engine: latches the M-stage access, issues one or
// two aligned word transactions, and returns the aligned, extended result.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [1:0]      req_size_i,
    input  logic [2:0]      req_ext_i,
    output logic            stall_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            done_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [3:0]      bus_be_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i
);

    state_e            state_q, state_d;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [1:0]        size_q;
    logic [2:0]        ext_q;
    logic              split_q;
    logic [XLEN-1:0]   lo_q;

    logic [XLEN-1:0]   base_addr;
    logic [XLEN-1:0]   lo_in;
    logic [XLEN-1:0]   hi_in;
    logic [7:0]        be8;
    logic [63:0]       wdata64;
    logic [XLEN-1:0]   ext_data;

    assign base_addr = {addr_q[XLEN-1:2], 2'b00};

    // The word arriving this cycle feeds the extractor directly, so the result
    // can be registered on the same edge that enters DONE.
    assign lo_in = (state_q == WAIT1) ? bus_rdata_i : lo_q;
    assign hi_in = (state_q == WAIT2) ? bus_rdata_i : '0;

    assign stall_o = req_valid_i && (state_q != DONE);

    dmem_lane_align u_align (
        .size      (size_q),
        .ext       (ext_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .lo        (lo_in),
        .hi        (hi_in),
        .be8       (be8),
        .wdata64   (wdata64),
        .load_data (ext_data)
    );

    // Next-state and bus/handshake outputs; bus fields are derived from latched
    // request state only, so they stay stable while a grant is pending.
    always_comb begin
        state_d     = state_q;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_be_o    = 4'h0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) state_d = REQ1;
            end
            REQ1: begin
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = base_addr;
                bus_wdata_o = wdata64[31:0];
                bus_be_o    = be8[3:0];
                if (bus_gnt_i) state_d = WAIT1;
            end
            WAIT1: begin
                if (bus_rvalid_i) state_d = split_q ? REQ2 : DONE;
            end
            REQ2: begin
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = base_addr + 32'd4;
                bus_wdata_o = wdata64[63:32];
                bus_be_o    = be8[7:4];
                if (bus_gnt_i) state_d = WAIT2;
            end
            WAIT2: begin
                if (bus_rvalid_i) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, request latch, low-word capture and load result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= 2'b00;
            ext_q       <= 3'b000;
            split_q     <= 1'b0;
            lo_q        <= '0;
            load_data_o <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if ((state_q == IDLE) && req_valid_i) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                size_q  <= req_size_i;
                ext_q   <= req_ext_i;
                split_q <= is_split(req_size_i, req_addr_i[1:0]);
            end
            if ((state_q == WAIT1) && bus_rvalid_i) lo_q <= bus_rdata_i;
            if ((state_d == DONE) && (state_q != DONE) && !we_q) load_data_o <= ext_data;
        end
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage load/store engine of the 6-stage core; turns the M-stage access (size, extension select, address, store data) into data-bus transactions.
- Returns the aligned, extended load result, which is registered into W alongside ResultSrcW, RegWriteW, ByteSrcW and ByteAccessW.
- Splits misaligned accesses into two aligned word transactions.
- Stalls the pipeline until the access completes.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid_i  in  1  M stage holds a load or store
- req_we_i  in  1  1=store, 0=load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_ext_i  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- stall_o  out  1  freeze IF..M stages
- load_data_o  out  32  extended load result, valid in DONE
- done_o  out  1  access completes this cycle
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word-aligned address
- bus_wdata_o  out  32  lane-positioned write data
- bus_be_o  out  4  byte enables
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  response (read data or write ack), one per accepted request
- bus_rdata_i  in  32  read data

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: state IDLE, all bus outputs 0, load_data_o 0, done_o 0, internal latches 0.
- stall_o is combinational: req_valid_i && state!=DONE.
- States and transitions:
  - IDLE: if req_valid_i, latch request, compute split, go REQ1.
  - REQ1: bus_req_o=1 with first-word fields; on bus_gnt_i go WAIT1; otherwise hold all fields stable.
  - WAIT1: on bus_rvalid_i capture rdata into lo; go REQ2 if split, else DONE.
  - REQ2: bus_req_o=1 with the second word at base+4 (32-bit wrap: 0xFFFFFFFC+4=0x0); on gnt go WAIT2.
  - WAIT2: on rvalid capture hi; go DONE.
  - DONE: done_o=1, stall_o=0, load_data_o valid (held until the next DONE); go IDLE.
- Latency (gnt same cycle, rvalid next): aligned access 4 cycles from IDLE to DONE; split access 6 cycles.
- Split condition: off=addr[1:0]; split when (half && off==3) || (word && off!=0).
- Lane math:
  - Byte enables: 8-bit mask = {1,3,F}[size] << off; low nibble used in txn1, high nibble in txn2.
  - Store data: 64-bit {32'b0, wdata} << 8*off; low word in txn1, high word in txn2.
  - Load: {hi,lo} >> 8*off, then sign/zero extension per req_ext_i; hi=0 when not split.
- bus_addr_o = {addr[31:2],2'b00} for txn1.
- bus_rvalid_i outside WAIT1/WAIT2 is ignored.
- Reset mid-transaction aborts to IDLE with bus_req_o low; any outstanding response is ignored.
- The request is latched in IDLE; changes on req_* during the access have no effect.
- A back-to-back request is accepted in IDLE the cycle after DONE.

Decomposition:
- Package dmem_pkg:
  - size enum (SZ_B, SZ_H, SZ_W).
  - ext funct3 constants.
  - state enum (IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE).
- One sub-module, dmem_lane_align: combinational byte-enable, store shift and load extract/extend.
- FSM and latches stay in the top.

Test Plan:
- Aligned LW 0x100, gnt immediate, rdata 0xDEADBEEF -> one txn, addr 0x100, be 1111, load_data 0xDEADBEEF, done 4 cycles after req.
- LB 0x103, rdata 0x80112233 -> be 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
- SW 0x201 data 0xAABBCCDD -> txn1 addr 0x200, be 1110, wdata 0xBBCCDD00; txn2 addr 0x204, be 0001, wdata 0x000000AA; done at cycle 6.
- LH 0xFFFFFFFF, rdata1 0x12xxxxxx, rdata2 0xxxxxxx34 -> txn2 addr 0x00000000, load_data 0x00003412; stall_o high until DONE.
- bus_gnt_i held low 3 cycles in REQ1 -> bus fields stable, stall_o high; a spurious rvalid in REQ1 is ignored.
- reset asserted in WAIT1 -> next edge IDLE, bus_req_o 0, done_o 0; new LW then completes normally.
